// File: rtl/uart_pkg.sv
// uart_pkg: shared types and encodings for the buffered UART transmitter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;
    localparam logic [1:0] PAR_RSVD = 2'd3;
    localparam int unsigned DATA_BITS_MIN = 5;
    // cfg_bits encodes N-5, so the index of the final data bit is N-1 = 4+bits.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
        return 3'(DATA_BITS_MIN - 1) + {1'b0, bits};
    endfunction
    function automatic logic parity_en(input logic [1:0] par);
        return par != PAR_NONE && par != PAR_RSVD;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with level count; push ignored when full, pop ignored when empty.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int LVL_W = 4,
    parameter int W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0]    wr_q, rd_q;
    logic [LVL_W-1:0] level_q;
    logic [W-1:0]     mem_q [DEPTH];
    logic             do_push, do_pop;
    assign full_o  = level_q == LVL_W'(DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: buffered UART transmitter with per-frame baud, data width, parity and stop config.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             txd,
    output logic             busy,
    output logic             tx_done,
    output logic [LVL_W-1:0] fifo_level
);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [1:0]       bits_q, bits_d, par_mode_q, par_mode_d;
    logic             stop2_q, stop2_d, stop_idx_q, stop_idx_d, acc_q, acc_d;
    logic [7:0]       shift_q, shift_d, fifo_rdata;
    logic [2:0]       idx_q, idx_d;
    logic             pop, fifo_full, fifo_empty, tick;

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W), .W(8)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s_valid),
        .pop_i   (pop),
        .wdata_i (s_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign s_ready = !fifo_full;
    assign busy    = state_q != IDLE || !fifo_empty;
    assign tick    = cnt_q == div_q;
    assign txd     = state_q == START  ? 1'b0 :
                     state_q == DATA   ? shift_q[0] :
                     state_q == PARITY ? acc_q ^ (par_mode_q == PAR_ODD) : 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (state_q == IDLE || tick) ? '0 : cnt_q + DIV_W'(1);
        div_d      = div_q;
        bits_d     = bits_q;
        par_mode_d = par_mode_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        acc_d      = acc_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        pop        = 1'b0;
        tx_done    = 1'b0;
        unique case (state_q)
            IDLE:   pop = !fifo_empty;
            START:  if (tick) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA:   if (tick) begin
                shift_d = shift_q >> 1;
                acc_d   = acc_q ^ shift_q[0];
                idx_d   = idx_q + 3'd1;
                if (idx_q == last_bit_idx(bits_q)) state_d = parity_en(par_mode_q) ? PARITY : STOP;
            end
            PARITY: if (tick) state_d = STOP;
            STOP:   if (tick) begin
                if (stop2_q && !stop_idx_q) stop_idx_d = 1'b1;
                else begin
                    tx_done = 1'b1;
                    pop     = !fifo_empty;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A pop always starts a new frame on the same edge, snapshotting config.
        if (pop) begin
            state_d    = START;
            cnt_d      = '0;
            div_d      = cfg_div;
            bits_d     = cfg_bits;
            par_mode_d = cfg_parity;
            stop2_d    = cfg_stop2;
            stop_idx_d = 1'b0;
            acc_d      = 1'b0;
            shift_d    = fifo_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bits_q     <= '0;
            par_mode_q <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            acc_q      <= 1'b0;
            shift_q    <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bits_q     <= bits_d;
            par_mode_q <= par_mode_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            acc_q      <= acc_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame with hand-computed frames.
module tb_uart_tx_frame;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cfg_div = 16'd3;
    logic [1:0]  cfg_bits = 2'd3, cfg_parity = 2'd0;
    logic        cfg_stop2 = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        txd, busy, tx_done;
    logic [3:0]  fifo_level;
    int          n_checks = 0;
    int          n_fails = 0;
    logic [7:0]  d4 [9] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E, 8'h18, 8'hE7};

    uart_tx_frame #(.DIV_W(16), .FIFO_DEPTH(8), .LVL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_div    (cfg_div),
        .cfg_bits   (cfg_bits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; byte is accepted on the following posedge.
    task automatic push(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Waits up to max_wait cycles for the start bit, then checks every cycle of the frame.
    // bits holds the expected line levels, first-sent in bit 0. Returns one cycle after the frame.
    task automatic run_frame(input string tag, input logic [11:0] bits, input int nbits, input int div,
                             input int max_wait);
        int w = 0;
        int len = nbits * (div + 1);
        while (txd !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_start"}, 32'(txd), 32'd0);
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            check({tag, "_txd"}, 32'(txd), 32'(bits[c / (div + 1)]));
            check({tag, "_done"}, 32'(tx_done), 32'(c == len - 1));
        end
        @(negedge clk);
    endtask

    initial begin
        #3;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 8N1, 4 clk/bit, 0xA5
        cfg_div = 16'd3; cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        push(8'hA5);
        check("t1_lat_idle", 32'(txd), 32'd1);
        check("t1_level", 32'(fifo_level), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        run_frame("t1", 12'h34A, 10, 3, 0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_level_end", 32'(fifo_level), 32'd0);

        // 7E2, 2 clk/bit, 0x41: 0 1000001 0 11
        cfg_div = 16'd1; cfg_bits = 2'd2; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
        push(8'h41);
        run_frame("t2", 12'h682, 11, 1, 2);
        check("t2_busy_end", 32'(busy), 32'd0);

        // 5O1, 1 clk/bit, 0xFF: 0 11111 0 1
        cfg_div = 16'd0; cfg_bits = 2'd0; cfg_parity = 2'd2; cfg_stop2 = 1'b0;
        push(8'hFF);
        run_frame("t3", 12'h0BE, 8, 0, 2);
        check("t3_busy_end", 32'(busy), 32'd0);

        // Nine back-to-back pushes, 8N1 at 1 clk/bit
        cfg_bits = 2'd3; cfg_parity = 2'd0;
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    check("t4_ready", 32'(s_ready), 32'd1);
                    s_valid = 1'b1;
                    s_data  = d4[i];
                    @(negedge clk);
                end
                s_valid = 1'b0;
                check("t4_full_level", 32'(fifo_level), 32'd8);
                check("t4_full_ready", 32'(s_ready), 32'd0);
            end
            begin
                for (int f = 0; f < 9; f++)
                    run_frame("t4", {2'b00, 1'b1, d4[f], 1'b0}, 10, 0, f == 0 ? 5 : 0);
                check("t4_busy_end", 32'(busy), 32'd0);
                check("t4_level_end", 32'(fifo_level), 32'd0);
                check("t4_ready_end", 32'(s_ready), 32'd1);
            end
        join

        // Divisor change mid-frame only affects the next frame
        cfg_div = 16'd3;
        push(8'h3C);
        push(8'hC3);
        fork
            begin
                run_frame("t5a", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 3, 2);
                run_frame("t5b", {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 7, 0);
                check("t5_busy_end", 32'(busy), 32'd0);
            end
            begin
                repeat (10) @(negedge clk);
                cfg_div = 16'd7;
            end
        join

        // Reset during data bits of the second of three queued frames
        begin
            int w = 0;
            bit saw_low = 0;
            bit saw_done = 0;
            cfg_div = 16'd1;
            push(8'hAA);
            push(8'h00);
            push(8'h77);
            while (tx_done !== 1'b1 && w < 40) begin
                @(negedge clk);
                w++;
            end
            check("t6_first_done", 32'(tx_done), 32'd1);
            repeat (4) @(negedge clk);
            check("t6_pre_txd", 32'(txd), 32'd0);
            check("t6_pre_level", 32'(fifo_level), 32'd1);
            #2;
            rst = 1'b0;
            #1;
            check("t6_rst_txd", 32'(txd), 32'd1);
            check("t6_rst_level", 32'(fifo_level), 32'd0);
            check("t6_rst_busy", 32'(busy), 32'd0);
            check("t6_rst_ready", 32'(s_ready), 32'd1);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (txd !== 1'b1) saw_low = 1;
                if (tx_done !== 1'b0) saw_done = 1;
            end
            check("t6_no_frame", 32'(saw_low), 32'd0);
            check("t6_no_done", 32'(saw_done), 32'd0);
            check("t6_idle_busy", 32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
